// File: rtl/rs_fu_issue_scheduler.sv
// rs_fu_issue_scheduler: registered RS-to-FU issue scheduler with per-FU occupancy counters.
// RS_SCHED_AGE_RR_EN enables the round-robin pointer; undefined gives fixed lowest-index-first priority.
`ifndef RS_ALU_ENTRIES_NUM
`define RS_ALU_ENTRIES_NUM 8
`endif
`ifndef NUM_OF_ALUS
`define NUM_OF_ALUS 2
`endif

module rs_fu_issue_scheduler #(
  parameter int NUM_OF_RS    = `RS_ALU_ENTRIES_NUM,
  parameter int NUM_OF_FU    = `NUM_OF_ALUS,
  parameter int FU_LATENCY   = 1,
  parameter int FU_IDX_WIDTH = (NUM_OF_FU <= 1) ? 1 : $clog2(NUM_OF_FU),
  parameter int RS_IDX_WIDTH = (NUM_OF_RS <= 1) ? 1 : $clog2(NUM_OF_RS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [NUM_OF_RS-1:0]                   rs_ready,
  input  logic [NUM_OF_FU-1:0]                   fu_available,
  output logic [NUM_OF_RS-1:0]                   rs_dispatch_en,
  output logic [NUM_OF_RS-1:0][FU_IDX_WIDTH-1:0] rs_fu_assign,
  output logic [NUM_OF_FU-1:0]                   fu_issue_valid,
  output logic [NUM_OF_FU-1:0][RS_IDX_WIDTH-1:0] fu_issue_rs_idx,
  output logic [NUM_OF_FU-1:0]                   fu_busy
);
  localparam int CW = $clog2(FU_LATENCY + 1);
  logic [NUM_OF_FU-1:0][CW-1:0]           busy_cnt;
  logic [RS_IDX_WIDTH-1:0]                rr_ptr;
  logic [NUM_OF_RS-1:0]                   en_n;
  logic [NUM_OF_RS-1:0][FU_IDX_WIDTH-1:0] asg_n;
  logic [NUM_OF_FU-1:0]                   fv_n;
  logic [NUM_OF_FU-1:0][RS_IDX_WIDTH-1:0] fidx_n;
  logic [NUM_OF_FU-1:0]                   avail;
  logic [RS_IDX_WIDTH-1:0]                ri;
  logic                                   got;
  int                                     idx;
`ifdef RS_SCHED_AGE_RR_EN
  logic [RS_IDX_WIDTH-1:0]                ptr_n;
`endif
  always_comb begin
    for (int f = 0; f < NUM_OF_FU; f++) fu_busy[f] = busy_cnt[f] != '0;
  end
  // Walk RS entries in priority order; each eligible one takes the lowest free FU left.
  always_comb begin
    en_n   = '0;
    asg_n  = '0;
    fv_n   = '0;
    fidx_n = '0;
    avail  = fu_available & ~fu_busy;
    ri     = '0;
    got    = 1'b0;
    idx    = 0;
`ifdef RS_SCHED_AGE_RR_EN
    ptr_n  = rr_ptr;
`endif
    for (int k = 0; k < NUM_OF_RS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_OF_RS) idx = idx - NUM_OF_RS;
      ri = RS_IDX_WIDTH'(idx);
      if (rs_ready[ri] && !rs_dispatch_en[ri] && |avail) begin
        got = 1'b0;
        for (int f = 0; f < NUM_OF_FU; f++) begin
          if (!got && avail[f]) begin
            got       = 1'b1;
            avail[f]  = 1'b0;
            fv_n[f]   = 1'b1;
            fidx_n[f] = ri;
            asg_n[ri] = FU_IDX_WIDTH'(f);
          end
        end
        en_n[ri] = 1'b1;
`ifdef RS_SCHED_AGE_RR_EN
        ptr_n = (ri == RS_IDX_WIDTH'(NUM_OF_RS - 1)) ? '0 : ri + 1'b1;
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_dispatch_en  <= '0;
      rs_fu_assign    <= '0;
      fu_issue_valid  <= '0;
      fu_issue_rs_idx <= '0;
      busy_cnt        <= '0;
    end else if (flush) begin
      rs_dispatch_en  <= '0;
      rs_fu_assign    <= '0;
      fu_issue_valid  <= '0;
      fu_issue_rs_idx <= '0;
      busy_cnt        <= '0;
    end else begin
      rs_dispatch_en  <= en_n;
      rs_fu_assign    <= asg_n;
      fu_issue_valid  <= fv_n;
      fu_issue_rs_idx <= fidx_n;
      for (int f = 0; f < NUM_OF_FU; f++)
        busy_cnt[f] <= fv_n[f] ? CW'(FU_LATENCY - 1) : (busy_cnt[f] != '0) ? busy_cnt[f] - 1'b1 : busy_cnt[f];
    end
  end
`ifdef RS_SCHED_AGE_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr <= '0;
    else if (!flush) rr_ptr <= ptr_n;
  end
`else
  assign rr_ptr = '0;
`endif
endmodule

// File: doc/rs_fu_issue_scheduler.md
# rs_fu_issue_scheduler

Registered, parametrised issue scheduler between the ALU reservation-station array and the functional units. It is the sequential successor of the combinational RS-to-FU scheduler. Each cycle it matches ready RS entries to free FUs and registers the grants. It tracks per-FU occupancy for multi-cycle (non-pipelined) units and provides round-robin fairness across RS entries.

## Interface
- NUM_OF_RS, default `RS_ALU_ENTRIES_NUM: number of RS entries.
- NUM_OF_FU, default `NUM_OF_ALUS: number of functional units.
- FU_LATENCY, default 1: cycles an FU stays occupied per issue; minimum 1, where 1 means fully pipelined.
- FU_IDX_WIDTH, default (NUM_OF_FU<=1)?1:$clog2(NUM_OF_FU): FU index width.
- RS_IDX_WIDTH, default (NUM_OF_RS<=1)?1:$clog2(NUM_OF_RS): RS index width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- rs_ready  in  NUM_OF_RS  level per entry: operands ready, entry valid.
- fu_available  in  NUM_OF_FU  external FU enable (stall/backpressure).
- rs_dispatch_en  out  NUM_OF_RS  registered one-cycle grant per RS entry.
- rs_fu_assign  out  [NUM_OF_RS] x FU_IDX_WIDTH  FU granted to each entry; meaningful only where rs_dispatch_en is set, 0 otherwise.
- fu_issue_valid  out  NUM_OF_FU  registered issue strobe per FU.
- fu_issue_rs_idx  out  [NUM_OF_FU] x RS_IDX_WIDTH  RS index issued to each FU; 0 when fu_issue_valid is low.
- fu_busy  out  NUM_OF_FU  occupancy counter nonzero.

## Operation
- **Eligible RS:** rs_ready[i] & ~rs_dispatch_en[i]. An entry granted last cycle is masked for the cycle its grant is visible, because the RS clears ready on that edge.
- **Free FU:** fu_available[f] & (busy_cnt[f]==0).
- **Matching:** FUs are visited in ascending index order. Each free FU takes the next eligible RS in priority order, starting at the round-robin pointer rr_ptr and wrapping modulo NUM_OF_RS.
  - No RS is granted twice.
  - Number of grants = min(#eligible, #free).
- **Pointer update:** if ≥1 grant, rr_ptr <= (last granted RS index + 1) mod NUM_OF_RS. With no grant, rr_ptr holds.
  - Wrap is explicit compare-and-reset; NUM_OF_RS need not be a power of 2.
- **Occupancy:** on issue to FU f, busy_cnt[f] <= FU_LATENCY-1. Otherwise it decrements while nonzero.
  - Counter width is $clog2(FU_LATENCY+1); it never underflows.
- **fu_busy:** fu_busy[f] = (busy_cnt[f]!=0).
- **Flush:** on the next edge, all grant outputs go to 0 and all busy_cnt clear to 0; rr_ptr is unchanged. Flush wins over any simultaneous match.
- **Reset (reset low):** asynchronously clears all outputs, busy_cnt, and rr_ptr to 0. This holds mid-operation too: occupied FUs become free immediately after release.

## Timing
- Latency is 1 cycle: rs_ready/fu_available sampled at edge E; grants visible in the cycle after E.
- All outputs are registered; there is no combinational input-to-output path.
- Grant pulse lasts exactly one cycle per issue.
- FU reuse: with FU_LATENCY=L, FU f granted at edge E is next grantable at edge E+L. L=1 allows back-to-back issue.
- fu_available deassertion blocks new grants from the same edge. It does not cancel grants already registered.
- Simultaneous flush and reset: reset dominates.

## Configuration
- RS_SCHED_AGE_RR_EN defined: round-robin rr_ptr as described.
- Macro undefined: rr_ptr is tied to 0 and its register is not built. Matching is then fixed-priority lowest-index-first, the previous generation's policy. All other behaviour is unchanged.

## Test plan
- **Reset:** drive reset low with random inputs → all outputs 0, fu_busy=0. Release → no grant until rs_ready is set.
- **Basic match** (NUM_OF_RS=8, NUM_OF_FU=2, L=1): rs_ready=8'h09, fu_available=2'b11 → next cycle:
  - rs_dispatch_en=8'h09
  - fu_issue_rs_idx[0]=0, fu_issue_rs_idx[1]=3
  - rs_fu_assign[3]=1
  - rr_ptr=4
- **Backpressure:** rs_ready=8'h10, fu_available=2'b00 for 2 cycles → no grants. Restore to 2'b11 → RS4 issued to FU0 one cycle later.
- **Fairness:** rs_ready=8'hFF held 4 cycles.
  - With RS_SCHED_AGE_RR_EN: grants {0,1},{2,3},{4,5},{6,7}.
  - Without: {0,1},{2,3},{0,1},{2,3}.
- **Multi-cycle FU** (L=3, NUM_OF_FU=2): rs_ready=8'h03, then 8'h0C from the next cycle → first pulse grants RS0/RS1. Then fu_busy=2'b11 for 2 cycles. RS2/RS3 dispatch exactly 3 cycles after the first pulse.
- **Flush/reset mid-busy** (L=3): issue, then flush one cycle later → fu_busy=0 and grant outputs 0 next cycle. Repeat with an async reset pulse between edges → outputs clear immediately, without waiting for clk.
